bsg_frame_serializer: RTL and testbench
=======================================

# bsg_frame_serializer

- Sits directly downstream of the BSG register bank.
- Takes a snapshot of the control word and the two data words (BSG_CONTROL / BSG_DATA_0 / BSG_DATA_1 values) when a send is requested.
- Drives them onto a single-bit, idle-high, UART-style line at a programmable bit period.
- Reports progress back to software-visible logic through BUSY and a one-cycle DONE pulse.

## Interface

Parameters:
- DATA_WIDTH, 8: width of control and data words, and number of payload bits per frame.
- CLK_DIV, 4: clock cycles per serial bit; legal range 1..255.

Ports:
- G_CLK_TX  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- CTRL_VALID  in  1  request strobe; CTRL_IN/DATA0_IN/DATA1_IN are sampled when it is high.
- CTRL_IN  in  DATA_WIDTH  control word:
  - bit0 START.
  - bit1 SEND_BOTH: 1 = DATA0 then DATA1; 0 = DATA0 only.
  - bit2 MSB_FIRST.
  - other bits ignored.
- DATA0_IN  in  DATA_WIDTH  first payload word.
- DATA1_IN  in  DATA_WIDTH  second payload word.
- TX_BIT  out  1  serial line, idle 1.
- TX_EN  out  1  high while a frame bit (start/data/parity/stop) is being driven.
- BUSY  out  1  high from acceptance until the transfer ends.
- DONE  out  1  one-cycle pulse at end of transfer.

## Operation

- Accept condition:
  - Required: CTRL_VALID=1, CTRL_IN[0]=1 and BUSY=0 in the same cycle.
  - On acceptance: CTRL_IN[2:1], DATA0_IN and DATA1_IN are latched into internal shadow registers.
  - Later changes on the inputs have no effect on the transfer in progress.
- Ignored requests:
  - CTRL_VALID while BUSY=1.
  - CTRL_VALID with START=0.
- Frame format, per word: start bit (0), DATA_WIDTH payload bits, optional parity bit (see Configuration), stop bit (1).
- Bit order:
  - LSB first by default.
  - MSB first when the latched MSB_FIRST=1.
- SEND_BOTH=1: the DATA1 frame follows the DATA0 stop bit immediately, with no idle gap.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> PARITY (macro on) or DATA -> STOP (macro off), after DATA_WIDTH bit periods.
  - PARITY -> STOP after CLK_DIV cycles.
  - STOP -> START if the second word is pending; otherwise STOP -> IDLE.
- Counters:
  - Bit-period counter: 8 bits, counts 0..CLK_DIV-1.
  - Bit index counter: $clog2(DATA_WIDTH)+1 bits.
  - Word counter: 1 bit.
  - All counters clear on accept and on rst.
- Parity: XOR of the latched DATA_WIDTH payload bits (even parity).

## Timing

- Reset values, after the first G_CLK_TX edge with rst=1:
  - TX_BIT=1, TX_EN=0, BUSY=0, DONE=0.
  - FSM=IDLE; shadow registers and counters all 0.
- Accept at edge N (inputs sampled): from edge N onward, TX_BIT=0, TX_EN=1, BUSY=1. All outputs are registered.
- Every frame bit is held for exactly CLK_DIV cycles. CLK_DIV=1 gives one bit per clock.
- Frame length per word:
  - Macro off: (DATA_WIDTH+2)*CLK_DIV cycles.
  - Macro on: (DATA_WIDTH+3)*CLK_DIV cycles.
- End of transfer, at the edge that ends the last stop-bit period:
  - FSM -> IDLE; BUSY=0, TX_EN=0, TX_BIT=1, DONE=1.
  - DONE clears on the next edge.
- A new accept in the DONE=1 cycle is legal. The new start bit follows the old stop bit with zero idle cycles.
- rst mid-transfer:
  - Next edge: all outputs return to reset values.
  - No DONE pulse is produced.
  - The partial frame is abandoned.
- rst has priority over a simultaneous CTRL_VALID; that request is dropped.

## Configuration

- BSG_PARITY_EN defined:
  - PARITY state compiled in.
  - One even-parity bit follows the last payload bit of each word, held CLK_DIV cycles.
- BSG_PARITY_EN undefined:
  - PARITY state and parity logic absent.
  - Frame is start, payload, stop.

## Test plan

All scenarios use DATA_WIDTH=8 and CLK_DIV=4 unless noted.

- Reset check: hold rst=1 for 2 cycles. Required: TX_BIT=1, TX_EN=0, BUSY=0, DONE=0; CTRL_VALID pulses during rst are not accepted.
- Single word, LSB first, macro off: CTRL_IN=0x01, DATA0_IN=0xA5. Required:
  - TX_BIT = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles.
  - BUSY high for 40 cycles.
  - DONE high in cycle 40 after accept.
- Two words: CTRL_IN=0x03, DATA0_IN=0x3C, DATA1_IN=0xC3. Required:
  - 80 contiguous frame cycles.
  - Second start bit immediately after first stop bit.
  - Exactly one DONE pulse.
- MSB first with CLK_DIV=1: CTRL_IN=0x05, DATA0_IN=0x80. Required:
  - TX_BIT = 0,1,0,0,0,0,0,0,0,1, one cycle each.
  - DONE at cycle 10.
- Ignored requests:
  - CTRL_VALID with CTRL_IN=0x00 leaves BUSY=0.
  - CTRL_VALID with DATA0_IN=0xFF during a 0xA5 transfer leaves the serial waveform unchanged.
- Reset mid-frame, then parity:
  - rst during data bit 3 -> next edge TX_BIT=1, BUSY=0, no DONE.
  - Then, with BSG_PARITY_EN defined, DATA0_IN=0x07 -> parity bit 1 and frame length 44 cycles.

Source files
------------

// File: rtl/bsg_frame_serializer.sv
// bsg_frame_serializer: snapshots the control word and two data words on a send
// request, then shifts them out as UART-style frames on an idle-high line.
// Optional even-parity bit per word is compiled in when BSG_PARITY_EN is defined.
module bsg_frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  G_CLK_TX,
    input  logic                  rst,
    input  logic                  CTRL_VALID,
    input  logic [DATA_WIDTH-1:0] CTRL_IN,
    input  logic [DATA_WIDTH-1:0] DATA0_IN,
    input  logic [DATA_WIDTH-1:0] DATA1_IN,
    output logic                  TX_BIT,
    output logic                  TX_EN,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [7:0]       LP_CNT_MAX  = 8'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef BSG_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state, w_state_d;
    logic [7:0]            r_cnt, w_cnt_d;
    logic [IDX_W-1:0]      r_idx, w_idx_d;
    logic                  r_word, w_word_d;
    logic                  r_send_both, r_msb_first;
    logic [DATA_WIDTH-1:0] r_data0, r_data1;
    logic                  r_tx_bit, r_tx_en, r_busy, r_done;

    logic                  w_accept, w_period_end, w_done_d, w_tx_bit_d;
    logic [DATA_WIDTH-1:0] w_word_sel, w_shift;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_unused_ctrl;

    // Only START/SEND_BOTH/MSB_FIRST are meaningful; the rest are dropped.
    assign w_unused_ctrl = ^CTRL_IN[DATA_WIDTH-1:3];

    assign w_accept     = CTRL_VALID & CTRL_IN[0] & ~r_busy;
    assign w_period_end = (r_cnt == LP_CNT_MAX);

    // Next-state logic: bit-period counter, bit index, word select and FSM.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_word_d  = r_word;
        w_done_d  = 1'b0;
        if (r_state != S_IDLE) begin
            w_cnt_d = w_period_end ? 8'd0 : r_cnt + 8'd1;
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_d = S_START;
                    w_cnt_d   = 8'd0;
                    w_idx_d   = '0;
                    w_word_d  = 1'b0;
                end
            end
            S_START: begin
                if (w_period_end) begin
                    w_state_d = S_DATA;
                    w_idx_d   = '0;
                end
            end
            S_DATA: begin
                if (w_period_end) begin
                    if (r_idx == LP_IDX_LAST) begin
                        w_idx_d   = '0;
`ifdef BSG_PARITY_EN
                        w_state_d = S_PARITY;
`else
                        w_state_d = S_STOP;
`endif
                    end else begin
                        w_idx_d = r_idx + 1'b1;
                    end
                end
            end
`ifdef BSG_PARITY_EN
            S_PARITY: begin
                if (w_period_end) begin
                    w_state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_period_end) begin
                    if (r_send_both && !r_word) begin
                        w_state_d = S_START;
                        w_word_d  = 1'b1;
                    end else begin
                        w_state_d = S_IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    // Line value for the upcoming cycle, derived from next state so outputs stay registered.
    always_comb begin
        w_word_sel = w_word_d ? r_data1 : r_data0;
        w_sel_idx  = r_msb_first ? (LP_IDX_LAST - w_idx_d) : w_idx_d;
        w_shift    = w_word_sel >> w_sel_idx;
        w_tx_bit_d = 1'b1;
        case (w_state_d)
            S_START:  w_tx_bit_d = 1'b0;
            S_DATA:   w_tx_bit_d = w_shift[0];
`ifdef BSG_PARITY_EN
            S_PARITY: w_tx_bit_d = ^w_word_sel;
`endif
            default:  w_tx_bit_d = 1'b1;
        endcase
    end

    // FSM state and counters.
    always_ff @(posedge G_CLK_TX) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_word  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_word  <= w_word_d;
        end
    end

    // Shadow copies of the request, frozen for the whole transfer.
    always_ff @(posedge G_CLK_TX) begin
        if (rst) begin
            r_send_both <= 1'b0;
            r_msb_first <= 1'b0;
            r_data0     <= '0;
            r_data1     <= '0;
        end else if (w_accept) begin
            r_send_both <= CTRL_IN[1];
            r_msb_first <= CTRL_IN[2];
            r_data0     <= DATA0_IN;
            r_data1     <= DATA1_IN;
        end
    end

    // Registered outputs.
    always_ff @(posedge G_CLK_TX) begin
        if (rst) begin
            r_tx_bit <= 1'b1;
            r_tx_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tx_bit <= w_tx_bit_d;
            r_tx_en  <= (w_state_d != S_IDLE);
            r_busy   <= (w_state_d != S_IDLE);
            r_done   <= w_done_d;
        end
    end

    assign TX_BIT = r_tx_bit;
    assign TX_EN  = r_tx_en;
    assign BUSY   = r_busy;
    assign DONE   = r_done;

endmodule

// File: tb/tb_bsg_frame_serializer.sv
// Self-checking bench for bsg_frame_serializer: table of directed frames plus
// hand sequences for reset, ignored requests, back-to-back accept and mid-frame reset.
module tb_bsg_frame_serializer;

`ifdef BSG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ctrl_valid = 1'b0;
    logic [7:0] ctrl_in = 8'h00;
    logic [7:0] data0_in = 8'h00;
    logic [7:0] data1_in = 8'h00;
    logic       tx4, en4, busy4, done4;
    logic       tx1, en1, busy1, done1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  ctrl;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          div;
        int          inject;
        int          words;
        logic [21:0] bits_np;  // transmission order, first bit leftmost
        logic [21:0] bits_p;
    } vec_t;

    vec_t vecs[6];
    vec_t vec_par;

    bsg_frame_serializer #(.DATA_WIDTH(8), .CLK_DIV(4)) dut4 (
        .G_CLK_TX  (clk),
        .rst       (rst),
        .CTRL_VALID(ctrl_valid),
        .CTRL_IN   (ctrl_in),
        .DATA0_IN  (data0_in),
        .DATA1_IN  (data1_in),
        .TX_BIT    (tx4),
        .TX_EN     (en4),
        .BUSY      (busy4),
        .DONE      (done4)
    );

    bsg_frame_serializer #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
        .G_CLK_TX  (clk),
        .rst       (rst),
        .CTRL_VALID(ctrl_valid),
        .CTRL_IN   (ctrl_in),
        .DATA0_IN  (data0_in),
        .DATA1_IN  (data1_in),
        .TX_BIT    (tx1),
        .TX_EN     (en1),
        .BUSY      (busy1),
        .DONE      (done1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs(input int div);
        return (div == 1) ? {tx1, en1, busy1, done1} : {tx4, en4, busy4, done4};
    endfunction

    // Compares {TX_BIT, TX_EN, BUSY, DONE}.
    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got tx/en/busy/done=%b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy4 || done4 || busy1 || done1) && n < 200) begin
            tick();
            n++;
        end
        check("idle_dut4", outs(4), 4'b1000);
        check("idle_dut1", outs(1), 4'b1000);
    endtask

    // Issues a request, checks every frame cycle, returns just after the DONE edge.
    task automatic run_vec(input vec_t v, input int id);
        int          wbits;
        int          nbits;
        int          len;
        logic [21:0] bits;
        wbits = PAR ? 11 : 10;
        nbits = v.words * wbits;
        len   = nbits * v.div;
        bits  = PAR ? v.bits_p : v.bits_np;
        ctrl_valid = 1'b1;
        ctrl_in    = v.ctrl;
        data0_in   = v.d0;
        data1_in   = v.d1;
        tick();
        ctrl_valid = 1'b0;
        ctrl_in    = ~v.ctrl;
        data0_in   = ~v.d0;
        data1_in   = ~v.d1;
        for (int c = 0; c < len; c++) begin
            check($sformatf("vec%0d_cyc%0d", id, c), outs(v.div),
                  {bits[nbits - 1 - c / v.div], 3'b110});
            if (c == v.inject) begin
                ctrl_valid = 1'b1;
                ctrl_in    = 8'h01;
                data0_in   = 8'hFF;
            end
            tick();
            if (c == v.inject) begin
                ctrl_valid = 1'b0;
            end
        end
        check($sformatf("vec%0d_done", id), outs(v.div), 4'b1001);
    endtask

    initial begin
        vecs[0] = '{8'h01, 8'hA5, 8'h00, 4, -1, 1, 22'b0101001011, 22'b01010010101};
        vecs[1] = '{8'h03, 8'h3C, 8'hC3, 4, -1, 2, 22'b00011110010110000111,
                    22'b0001111000101100001101};
        vecs[2] = '{8'h05, 8'h80, 8'h00, 1, -1, 1, 22'b0100000001, 22'b01000000011};
        vecs[3] = '{8'h01, 8'hA5, 8'h5A, 4, 14, 1, 22'b0101001011, 22'b01010010101};
        vecs[4] = '{8'h07, 8'h12, 8'hF0, 4, -1, 2, 22'b00001001010111100001,
                    22'b0000100100101111000001};
        vecs[5] = '{8'hF9, 8'h5A, 8'hFF, 4, -1, 1, 22'b0010110101, 22'b00101101001};
        vec_par = '{8'h01, 8'h07, 8'h00, 4, -1, 1, 22'b0111000001, 22'b01110000011};

        // Reset with a valid request pending: request must be dropped.
        rst        = 1'b1;
        ctrl_valid = 1'b1;
        ctrl_in    = 8'h01;
        data0_in   = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset%0d_dut4", i), outs(4), 4'b1000);
            check($sformatf("reset%0d_dut1", i), outs(1), 4'b1000);
        end
        rst        = 1'b0;
        ctrl_valid = 1'b0;
        tick();
        check("post_reset_idle", outs(4), 4'b1000);

        // START=0 requests are ignored.
        ctrl_valid = 1'b1;
        ctrl_in    = 8'h00;
        tick();
        check("nostart_00_dut4", outs(4), 4'b1000);
        check("nostart_00_dut1", outs(1), 4'b1000);
        ctrl_in = 8'h06;
        tick();
        check("nostart_06_dut4", outs(4), 4'b1000);
        ctrl_valid = 1'b0;
        tick();

        // Directed frame table.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            tick();
            check($sformatf("vec%0d_done_clr", i), outs(vecs[i].div), 4'b1000);
            wait_idle();
        end

        // Accept in the DONE cycle: start bit on the very next edge.
        run_vec(vecs[0], 10);
        ctrl_valid = 1'b1;
        ctrl_in    = 8'h01;
        data0_in   = 8'h07;
        tick();
        ctrl_valid = 1'b0;
        check("chain_start", outs(4), 4'b0110);
        wait_idle();

        // Reset during data bit 3 of 0xA5.
        ctrl_valid = 1'b1;
        ctrl_in    = 8'h01;
        data0_in   = 8'hA5;
        tick();
        ctrl_valid = 1'b0;
        for (int c = 0; c < 17; c++) begin
            tick();
        end
        check("midreset_bit3", outs(4), 4'b0110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_dut4", outs(4), 4'b1000);
        check("midreset_dut1", outs(1), 4'b1000);
        for (int c = 0; c < 45; c++) begin
            tick();
            check($sformatf("midreset_quiet%0d", c), outs(4), 4'b1000);
        end

        // 0x07: parity bit 1 when parity is compiled in.
        run_vec(vec_par, 20);
        tick();
        check("vecpar_done_clr", outs(4), 4'b1000);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
